count_capture_fifo: RTL
=======================

COUNT_CAPTURE_FIFO -- requirements
Module: count_capture_fifo

Interface
REQ-001 Parameter WIDTH, default 8: width of the captured count value.
REQ-002 Parameter DEPTH, default 4: FIFO entries; power of two, at least 2.
REQ-003 clk  input  1  single clock, rising-edge active.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cnt_i  input  WIDTH  count bus from the upstream counter.
REQ-006 cnt_oe_i  input  1  upstream output enable; captures are qualified by it.
REQ-007 cap_i  input  1  capture strobe, level input; its rising edge is an event.
REQ-008 match_en_i  input  1  enables compare-match capture.
REQ-009 cmp_i  input  WIDTH  compare value.
REQ-010 clr_i  input  1  synchronous flush plus overflow clear.
REQ-011 rd_ready_i  input  1  consumer accepts the head entry.
REQ-012 rd_valid_o  output  1  head entry is valid.
REQ-013 rd_data_o  output  WIDTH  captured count at the head.
REQ-014 rd_src_o  output  2  head source flags, {match, strobe}.
REQ-015 level_o  output  clog2(DEPTH)+1  number of occupied entries.
REQ-016 full_o / empty_o  output  1 each  occupancy flags.
REQ-017 ovf_o  output  1  sticky overflow flag.

Function
REQ-018 Strobe event:
- Fires in cycle N when cap_i=1 in cycle N and cap_i was 0 in cycle N-1.
- The previous-cycle value comes from a registered copy of cap_i.
REQ-019 Match event:
- Fires in cycle N when match_en_i=1 and cnt_i==cmp_i, and that condition was false in cycle N-1.
- Gives one event per entry into the matching state.
REQ-020 Push qualification: a push is requested in cycle N when (strobe or match) and cnt_oe_i=1; a qualifying event with cnt_oe_i=0 is discarded without setting ovf_o.
REQ-021 Combined events: if strobe and match fire in the same cycle, exactly one entry is pushed, with rd_src_o={1,1}.
REQ-022 Entry contents: each entry stores cnt_i as sampled in cycle N, plus the {match, strobe} flags of cycle N.
REQ-023 Write timing: the entry is written at the rising edge that ends cycle N. If the FIFO was empty, rd_valid_o=1 in cycle N+1. Latency is 1 cycle; there is no combinational bypass.
REQ-024 Pop: occurs at a rising edge when rd_valid_o=1 and rd_ready_i=1; rd_ready_i is ignored while empty_o=1.
REQ-025 Head stability: rd_data_o and rd_src_o are driven from the head entry and stay stable while rd_valid_o=1 and rd_ready_i=0.
REQ-026 Simultaneous push and pop while full: both are performed and the level is unchanged.
REQ-027 Simultaneous push and pop while empty: only the push is performed (REQ-024).
REQ-028 Overflow: a push request while full with no pop in the same cycle is dropped, and ovf_o is set to 1 at that edge.
REQ-029 ovf_o stays 1 until clr_i or reset clears it.
REQ-030 Flush: clr_i=1 at an edge overrides push and pop. At that edge the FIFO is emptied and ovf_o is cleared; the edge detector registers still update normally.
REQ-031 Pointers: read and write pointers are clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-032 Occupancy: level_o ranges 0..DEPTH; full_o=(level_o==DEPTH); empty_o=(level_o==0); rd_valid_o=~empty_o.
REQ-033 All outputs are registered or derived from registered state only; no combinational path from any input to any output.

Reset
REQ-034 While reset=1, regardless of clk:
- level_o=0, empty_o=1, full_o=0, rd_valid_o=0, ovf_o=0.
- rd_data_o=0 and rd_src_o=0.
- Pointers=0 and the edge/match history registers=0.
REQ-035 Reset asserted mid-operation discards all stored entries immediately.
REQ-036 After reset deasserts:
- Operation resumes at the next rising edge.
- If cap_i=1 at that edge, it counts as a strobe event, because the history register is 0.

Verification
REQ-037 Bench scenario: cnt_oe_i=1, cnt_i=8'h2A, cap_i 0->1 held for 3 cycles -> exactly one entry; one cycle later rd_valid_o=1, rd_data_o=8'h2A, rd_src_o=2'b01, level_o=1.
REQ-038 Bench scenario: match_en_i=1, cmp_i=8'h05, cnt_i steps 03,04,05,05,06 -> one entry with data 8'h05 and rd_src_o=2'b10.
REQ-039 Bench scenario: same cycle as REQ-038's match, cap_i rises -> single entry with rd_src_o=2'b11.
REQ-040 Bench scenario: DEPTH=4, five strobes with values 1..5 and rd_ready_i=0 -> full_o=1, ovf_o=1; then pops return 1,2,3,4 in order; clr_i clears ovf_o.
REQ-041 Bench scenario: full FIFO, strobe with value 9 and rd_ready_i=1 in the same cycle -> level_o stays 4, ovf_o=0, and the final entry read is 9.
REQ-042 Bench scenario: strobe with cnt_oe_i=0 -> no entry and ovf_o unchanged; then reset pulsed with two entries stored -> empty_o=1 and rd_valid_o=0 while reset=1.

Source files
------------

// File: rtl/count_capture_fifo_if.sv
// Read-side handshake bundle for count_capture_fifo: head entry data, source flags,
// and the valid/ready pair between the FIFO (master) and its consumer (slave).
interface count_capture_fifo_if #(
  parameter int WIDTH = 8
);
  logic             rd_valid_o;
  logic             rd_ready_i;
  logic [WIDTH-1:0] rd_data_o;
  logic [1:0]       rd_src_o;

  modport master (
    output rd_valid_o,
    output rd_data_o,
    output rd_src_o,
    input  rd_ready_i
  );

  modport slave (
    input  rd_valid_o,
    input  rd_data_o,
    input  rd_src_o,
    output rd_ready_i
  );
endinterface

// File: rtl/count_capture_fifo.sv
// Captures an upstream count value into a small FIFO on a capture-strobe rising edge
// or on entry into a compare-match state, tagging each entry with its {match, strobe} source.
module count_capture_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         cnt_i,
  input  logic                     cnt_oe_i,
  input  logic                     cap_i,
  input  logic                     match_en_i,
  input  logic [WIDTH-1:0]         cmp_i,
  input  logic                     clr_i,
  count_capture_fifo_if.master     rd,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     ovf_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = WIDTH + 2;

  logic [EW-1:0] mem [DEPTH];

  logic          cap_reg;
  logic          match_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [LW-1:0] level_reg;
  logic          ovf_reg;

  logic          match_now;
  logic          strobe_ev;
  logic          match_ev;
  logic          push_req;
  logic          pop_req;
  logic          full;
  logic          do_push;
  logic          do_pop;
  logic [EW-1:0] head;

  // Events fire only on the transition into the active condition.
  assign match_now = match_en_i && (cnt_i == cmp_i);
  assign strobe_ev = cap_i && !cap_reg;
  assign match_ev  = match_now && !match_reg;
  assign push_req  = (strobe_ev || match_ev) && cnt_oe_i;

  assign full      = (level_reg == LW'(DEPTH));
  assign pop_req   = (level_reg != '0) && rd.rd_ready_i;
  assign do_push   = push_req && (!full || pop_req) && !clr_i;
  assign do_pop    = pop_req && !clr_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_reg    <= 1'b0;
      match_reg  <= 1'b0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      cap_reg   <= cap_i;
      match_reg <= match_now;
      if (clr_i) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        level_reg  <= '0;
        ovf_reg    <= 1'b0;
      end else begin
        if (do_push) begin
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
        end
        if (do_pop) begin
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
        if (do_push && !do_pop) begin
          level_reg <= level_reg + 1'b1;
        end else if (!do_push && do_pop) begin
          level_reg <= level_reg - 1'b1;
        end
        // Push while full is dropped unless a pop frees the slot at the same edge.
        if (push_req && full && !pop_req) begin
          ovf_reg <= 1'b1;
        end
      end
    end
  end

  // Storage carries no reset; outputs are masked while empty instead.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= {match_ev, strobe_ev, cnt_i};
    end
  end

  assign head = mem[rd_ptr_reg];

  assign rd.rd_valid_o = (level_reg != '0);
  assign rd.rd_data_o  = rd.rd_valid_o ? head[WIDTH-1:0] : '0;
  assign rd.rd_src_o   = rd.rd_valid_o ? head[EW-1:WIDTH] : 2'b00;

  assign level_o = level_reg;
  assign full_o  = full;
  assign empty_o = (level_reg == '0);
  assign ovf_o   = ovf_reg;

endmodule
